pipeline_hazard_unit: RTL and testbench

Data/control hazard unit for the RV32I 3-stage pipeline (fetch/decode, execute, memory/writeback).
- Compares source registers of the instruction in EXEC against the destination of the instruction in MEM and drives operand-forwarding selects.
- Raises a one-cycle load-use stall.
- Raises a flush on a taken branch/jump.

---
 rtl/hazard_pkg.sv | 41 ++++
 rtl/hazard_inst_decode.sv | 35 +++
 rtl/pipeline_hazard_unit.sv | 67 ++++++
 tb/tb_pipeline_hazard_unit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and opcode constants for the RV32I hazard unit.
// The opcode helpers are only called when HAZARD_OPCODE_CHECK_EN is defined.
package hazard_pkg;

    localparam int REG_AW = 5;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic              rs1_used;
        logic              rs2_used;
        logic              rd_valid;
    } inst_fields_t;

    function automatic logic op_uses_rs1(input logic [6:0] op);
        return (op == OP_R) || (op == OP_IMM) || (op == OP_LOAD) ||
               (op == OP_STORE) || (op == OP_BRANCH) || (op == OP_JALR);
    endfunction

    function automatic logic op_uses_rs2(input logic [6:0] op);
        return (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

    function automatic logic op_writes_rd(input logic [6:0] op);
        return (op == OP_R) || (op == OP_IMM) || (op == OP_LOAD) ||
               (op == OP_JAL) || (op == OP_JALR) || (op == OP_LUI) ||
               (op == OP_AUIPC);
    endfunction

endpackage

// File: rtl/hazard_inst_decode.sv
// Register-field decoder: instruction word -> rs1/rs2/rd plus validity flags.
// Optional macro HAZARD_OPCODE_CHECK_EN: qualify each field by opcode;
// otherwise every field is treated as live.
module hazard_inst_decode
    import hazard_pkg::*;
#(
    parameter int ILEN = 32
) (
    input  logic [ILEN-1:0] inst,
    output inst_fields_t    fields
);

    logic unused_bits;

    // Slice the fixed RV32I register fields and qualify them.
    always_comb begin
        fields     = '0;
        fields.rs1 = inst[19:15];
        fields.rs2 = inst[24:20];
        fields.rd  = inst[11:7];
`ifdef HAZARD_OPCODE_CHECK_EN
        fields.rs1_used = op_uses_rs1(inst[6:0]);
        fields.rs2_used = op_uses_rs2(inst[6:0]);
        fields.rd_valid = op_writes_rd(inst[6:0]);
`else
        fields.rs1_used = 1'b1;
        fields.rs2_used = 1'b1;
        fields.rd_valid = 1'b1;
`endif
    end

    // funct3/funct7/immediate bits play no part in hazard detection.
    assign unused_bits = ^{inst[ILEN-1:25], inst[14:12], inst[6:0]};

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard unit for the 3-stage RV32I pipeline: MEM->EXEC forwarding selects,
// one-cycle load-use stall and branch flush.
// Optional macro HAZARD_OPCODE_CHECK_EN: opcode-qualified register fields.
module pipeline_hazard_unit #(
    parameter int ILEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            reg_wr,
    input  logic            mem_read,
    input  logic            sel_for_branch,
    input  logic [ILEN-1:0] inst_exec,
    input  logic [ILEN-1:0] inst_mem,
    output logic            forward_sel_1,
    output logic            forward_sel_2,
    output logic            flush_sel,
    output logic            stall_sel
);
    import hazard_pkg::*;

    inst_fields_t      f_exec;
    inst_fields_t      f_mem;
    logic [REG_AW-1:0] rd_mem;
    logic              rd_mem_live;
    logic              match1;
    logic              match2;
    logic              stall_raw;
    logic              stall_q;
    logic              unused_fields;

    hazard_inst_decode #(.ILEN(ILEN)) u_dec_exec (
        .inst   (inst_exec),
        .fields (f_exec)
    );

    hazard_inst_decode #(.ILEN(ILEN)) u_dec_mem (
        .inst   (inst_mem),
        .fields (f_mem)
    );

    // x0 is hard-wired zero, so a write to it is never a producer.
    assign rd_mem      = f_mem.rd;
    assign rd_mem_live = reg_wr & f_mem.rd_valid & (rd_mem != '0);
    assign match1      = rd_mem_live & f_exec.rs1_used & (f_exec.rs1 == rd_mem);
    assign match2      = rd_mem_live & f_exec.rs2_used & (f_exec.rs2 == rd_mem);
    assign stall_raw   = mem_read & (match1 | match2);

    // Outputs are combinational and forced low for the whole reset window.
    assign forward_sel_1 = ~rst & match1;
    assign forward_sel_2 = ~rst & match2;
    assign flush_sel     = ~rst & sel_for_branch;
    assign stall_sel     = ~rst & stall_raw & ~stall_q & ~sel_for_branch;

    // Remember last cycle's stall so a load-use bubble is never repeated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= 1'b0;
        end else begin
            stall_q <= stall_sel;
        end
    end

    assign unused_fields = ^{f_exec.rd, f_exec.rd_valid, f_mem.rs1, f_mem.rs2,
                             f_mem.rs1_used, f_mem.rs2_used};

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed bench for pipeline_hazard_unit with an expected-value queue.
module tb_pipeline_hazard_unit;

    localparam int ILEN = 32;

    localparam logic [31:0] I_ZERO    = 32'h0000_0000;
    localparam logic [31:0] I_NOP     = 32'h0000_0013; // addi x0,x0,0
    localparam logic [31:0] I_SUB     = 32'h4031_02B3; // sub x5,x2,x3
    localparam logic [31:0] I_SLL     = 32'h0021_1133; // sll x2,x2,x2
    localparam logic [31:0] I_ADD_23  = 32'h0031_0333; // add x6,x2,x3
    localparam logic [31:0] I_ADD_32  = 32'h0021_8333; // add x6,x3,x2
    localparam logic [31:0] I_ADDI_X2 = 32'h0010_0113; // addi x2,x0,1
    localparam logic [31:0] I_LW_X2   = 32'h0000_2103; // lw x2,0(x0)

    logic            clk = 1'b0;
    logic            rst;
    logic            reg_wr;
    logic            mem_read;
    logic            sel_for_branch;
    logic [ILEN-1:0] inst_exec;
    logic [ILEN-1:0] inst_mem;
    logic            forward_sel_1;
    logic            forward_sel_2;
    logic            flush_sel;
    logic            stall_sel;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // expected {fwd1, fwd2, flush, stall}
    logic [3:0] exp_q[$];
    string      tag_q[$];

    always #5 clk = ~clk;

    pipeline_hazard_unit #(.ILEN(ILEN), .REG_AW(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .reg_wr         (reg_wr),
        .mem_read       (mem_read),
        .sel_for_branch (sel_for_branch),
        .inst_exec      (inst_exec),
        .inst_mem       (inst_mem),
        .forward_sel_1  (forward_sel_1),
        .forward_sel_2  (forward_sel_2),
        .flush_sel      (flush_sel),
        .stall_sel      (stall_sel)
    );

    task automatic drive(input logic rw, input logic mr, input logic br,
                         input logic [31:0] ie, input logic [31:0] im);
        reg_wr         = rw;
        mem_read       = mr;
        sel_for_branch = br;
        inst_exec      = ie;
        inst_mem       = im;
    endtask

    task automatic expect_out(input logic [3:0] e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check_one(input string tag, input string name,
                             input logic got, input logic want);
        total_cnt++;
        assert (got === want) pass_cnt++;
        else $error("FAIL %s.%s got=%b want=%b", tag, name, got, want);
    endtask

    task automatic check();
        logic [3:0] e;
        string      t;
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check_one(t, "fwd1",  forward_sel_1, e[3]);
        check_one(t, "fwd2",  forward_sel_2, e[2]);
        check_one(t, "flush", flush_sel,     e[1]);
        check_one(t, "stall", stall_sel,     e[0]);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0, I_SLL, I_SLL);
        expect_out(4'b0000, "reset");
        check();

        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, I_ZERO, I_ZERO);
        expect_out(4'b0000, "idle");
        check();
        step();

        drive(1'b1, 1'b0, 1'b0, I_NOP, I_NOP);
        expect_out(4'b0000, "x0_write");
        check();
        step();

        drive(1'b1, 1'b0, 1'b0, I_SUB, I_SUB);
        expect_out(4'b0000, "no_dep");
        check();
        step();

        drive(1'b1, 1'b0, 1'b0, I_ADD_23, I_ADDI_X2);
        expect_out(4'b1000, "fwd_rs1");
        check();
        step();

        drive(1'b1, 1'b1, 1'b0, I_ADD_32, I_LW_X2);
        expect_out(4'b0101, "load_rs2");
        check();
        step();

        expect_out(4'b0100, "load_rs2_hold");
        check();
        step();

        drive(1'b1, 1'b1, 1'b0, I_SLL, I_SLL);
        expect_out(4'b1101, "lu_c0");
        check();
        step();

        expect_out(4'b1100, "lu_c1");
        check();
        step();

        expect_out(4'b1101, "lu_c2");
        check();
        step();

        drive(1'b0, 1'b0, 1'b1, I_ZERO, I_ZERO);
        expect_out(4'b0010, "branch");
        check();
        step();

        drive(1'b1, 1'b1, 1'b1, I_SLL, I_SLL);
        expect_out(4'b1110, "branch_lu");
        check();
        step();

        drive(1'b0, 1'b1, 1'b0, I_SLL, I_SLL);
        expect_out(4'b0000, "load_no_wr");
        check();
        step();

        drive(1'b1, 1'b1, 1'b0, I_SLL, I_SLL);
        expect_out(4'b1101, "pre_rst_stall");
        check();
        #2;
        rst = 1'b1;
        expect_out(4'b0000, "rst_async");
        check();
        step();
        expect_out(4'b0000, "rst_held");
        check();

        rst = 1'b0;
        expect_out(4'b1101, "post_rst_stall");
        check();
        step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
